// File: rtl/rx_word_packer.sv
// Bit-serial to word deserialiser with a small word FIFO. Each buffered word is
// presented with an extract-enable that lasts exactly SYM_PER_WORD symbol slots.
module rx_word_packer #(
    parameter int DATA_W       = 16,
    parameter int SYM_PER_WORD = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_bit,
    input  logic                          i_bit_valid,
    input  logic                          i_hold,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_en_extract,
    output logic                          o_word_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow
);

    localparam int BW = $clog2(DATA_W);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (SYM_PER_WORD > 1) ? $clog2(SYM_PER_WORD) : 1;

    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [SW-1:0] LAST_SYM = SW'(SYM_PER_WORD - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   shift;
    logic [BW-1:0]       bit_cnt;
    logic [SW-1:0]       sym_cnt, sym_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                en_nxt, done_nxt;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         level;

    logic                push, push_ok, pop, fifo_empty, fifo_full;
    logic [DATA_W-1:0]   push_word;

    assign push       = i_bit_valid && (bit_cnt == LAST_BIT);
    assign push_word  = {shift[DATA_W-2:0], i_bit};
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == DEPTH);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok    = push && (!fifo_full || pop);

    assign o_fifo_level = level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (i_bit_valid) begin
            shift   <= push_word;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push && !push_ok) o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sym_cnt      <= '0;
            o_data       <= '0;
            o_en_extract <= 1'b0;
            o_word_done  <= 1'b0;
        end else begin
            state        <= state_nxt;
            sym_cnt      <= sym_nxt;
            o_data       <= data_nxt;
            o_en_extract <= en_nxt;
            o_word_done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sym_nxt   = sym_cnt;
        data_nxt  = o_data;
        en_nxt    = o_en_extract;
        done_nxt  = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                en_nxt = 1'b0;
                if (!fifo_empty && !i_hold) begin
                    pop       = 1'b1;
                    data_nxt  = mem[rd_ptr];
                    en_nxt    = 1'b1;
                    sym_nxt   = '0;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (o_en_extract && (sym_cnt == LAST_SYM)) begin
                    done_nxt = 1'b1;
                    // Chain straight into the next word to keep the enable contiguous.
                    if (!fifo_empty && !i_hold) begin
                        pop      = 1'b1;
                        data_nxt = mem[rd_ptr];
                        sym_nxt  = '0;
                        en_nxt   = 1'b1;
                    end else begin
                        en_nxt    = 1'b0;
                        state_nxt = IDLE;
                    end
                end else begin
                    if (o_en_extract) sym_nxt = sym_cnt + 1'b1;
                    en_nxt = !i_hold;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rx_word_packer.sv
// Scoreboard bench for rx_word_packer: the driver runs a slot/queue reference model,
// a separate monitor checks every cycle and every emitted word.
module tb_rx_word_packer;

    localparam int DW    = 16;
    localparam int SPW   = 4;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_bit = 1'b0, i_bit_valid = 1'b0, i_hold = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_en_extract, o_word_done, o_overflow;
    logic [1:0]    o_fifo_level;

    rx_word_packer #(.DATA_W(DW), .SYM_PER_WORD(SPW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_bit(i_bit), .i_bit_valid(i_bit_valid), .i_hold(i_hold),
        .o_data(o_data), .o_en_extract(o_en_extract), .o_word_done(o_word_done),
        .o_fifo_level(o_fifo_level), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lvl;
        bit ovf;
        bit en;
        bit done;
    } cyc_t;

    cyc_t          cyc_q[$];
    logic [DW-1:0] exp_q[$];

    int tests = 0;
    int fails = 0;

    // reference model state
    int            m_nbits, m_lvl, m_left;
    bit            m_ovf, m_en;
    logic [DW-1:0] m_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_nbits = 0; m_lvl = 0; m_left = 0; m_ovf = 0; m_en = 0; m_acc = '0;
        cyc_q.delete();
        exp_q.delete();
    endtask

    // One clock edge of behaviour: slots of the word in flight, FIFO occupancy, words.
    task automatic model(input logic v, input logic b, input logic h);
        bit   consume, pop, done_n, en_n;
        int   left;
        cyc_t e;
        consume = m_en;
        pop     = 0;
        done_n  = 0;
        left    = m_left - (consume ? 1 : 0);
        if (left == 0) begin
            done_n = consume;
            if (m_lvl > 0 && !h) begin
                pop = 1; left = SPW; en_n = 1;
            end else begin
                en_n = 0;
            end
        end else begin
            en_n = !h;
        end
        m_left = left;
        m_en   = en_n;
        if (v) begin
            m_acc = {m_acc[DW-2:0], b};
            m_nbits++;
            if (m_nbits == DW) begin
                m_nbits = 0;
                if (m_lvl < DEPTH || pop) begin
                    exp_q.push_back(m_acc);
                    m_lvl++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        if (pop) m_lvl--;
        e.lvl = m_lvl; e.ovf = m_ovf; e.en = en_n; e.done = done_n;
        cyc_q.push_back(e);
    endtask

    task automatic step(input logic v, input logic b, input logic h);
        @(negedge clk);
        i_bit_valid = v; i_bit = b; i_hold = h;
        model(v, b, h);
        @(posedge clk);
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, h);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input bit gapped, input logic h);
        for (int i = DW - 1; i >= 0; i--) begin
            if (gapped) step(1'b0, 1'b1, h);
            step(1'b1, w[i], h);
        end
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++) step(1'b1, w[DW-1-i], 1'b0);
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        i_bit_valid = 1'b0; i_bit = 1'b0; i_hold = 1'b0;
        #1;
        chk("rst_data", 32'(o_data), 32'h0);
        chk("rst_en", 32'(o_en_extract), 32'h0);
        chk("rst_done", 32'(o_word_done), 32'h0);
        chk("rst_level", 32'(o_fifo_level), 32'h0);
        chk("rst_ovf", 32'(o_overflow), 32'h0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: per-cycle expectations plus the ordered stream of emitted words.
    initial begin
        int            mon_cnt;
        bit            done_pend;
        logic [DW-1:0] cur;
        cyc_t          e;
        mon_cnt = 0; done_pend = 0; cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mon_cnt = 0; done_pend = 0; cur = '0;
                continue;
            end
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("level", 32'(o_fifo_level), 32'(e.lvl));
                chk("overflow", 32'(o_overflow), 32'(e.ovf));
                chk("en_extract", 32'(o_en_extract), 32'(e.en));
                chk("word_done_cyc", 32'(o_word_done), 32'(e.done));
            end
            chk("word_done_after_slots", 32'(o_word_done), 32'(done_pend));
            done_pend = 0;
            if (o_en_extract) begin
                if (mon_cnt == 0) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_word: got 0x%0h expected none at %0t", o_data, $time);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                chk("data", 32'(o_data), 32'(cur));
                mon_cnt++;
                if (mon_cnt == SPW) begin
                    mon_cnt = 0;
                    done_pend = 1;
                end
            end else begin
                chk("data_hold", 32'(o_data), 32'(cur));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        do_reset();

        // single word
        send_word(16'hA5C3, 0, 1'b0);
        idle(8, 1'b0);

        // gapped input
        send_word(16'h1234, 1, 1'b0);
        idle(8, 1'b0);

        // back-to-back after preloading under hold
        send_word(16'hFFFF, 0, 1'b1);
        send_word(16'h0001, 0, 1'b1);
        idle(12, 1'b0);

        // hold in the middle of a word
        send_word(16'h5A5A, 0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);
        idle(8, 1'b0);

        // overflow: third word dropped
        send_word(16'h1111, 0, 1'b1);
        send_word(16'h2222, 0, 1'b1);
        send_word(16'h3333, 0, 1'b1);
        idle(14, 1'b0);

        // reset mid-word, then a fresh word
        do_reset();
        send_bits(16'hCAFE, 9);
        do_reset();
        send_word(16'hBEEF, 0, 1'b0);
        idle(2, 1'b0);
        // reset mid-emission
        do_reset();
        send_word(16'h0F0F, 0, 1'b0);
        idle(8, 1'b0);

        // randomized traffic, light hold
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 9) < 3));
        idle(12, 1'b0);

        // randomized traffic, heavy hold to force overflows
        do_reset();
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'($urandom), ($urandom_range(0, 9) < 8));
        idle(20, 1'b0);

        chk("all_words_emitted", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
